systolic_sequencer: RTL and testbench

- Job controller for the 8x8 systolic_array (8-bit PEs, 64-bit row buses, one-hot column load).
- Per job it accepts 8 weight columns and loads them into the array, one column per beat. It then streams num_rows activation vectors into the array and collects the results into an output FIFO.
- The array has no backpressure, so input issue is credit-limited and results are never dropped.
- Sits between the host DMA/stream logic and systolic_array.

---
 rtl/systolic_pkg.sv | 26 ++
 rtl/systolic_sequencer_result_fifo.sv | 63 ++++++
 rtl/systolic_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_systolic_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared constants, FSM state type and result payload for the systolic job controller.
package systolic_pkg;

  localparam int unsigned ARRAY_DIM = 8;
  localparam int unsigned PE_W      = 8;
  localparam int unsigned BUS_W     = ARRAY_DIM * PE_W;
  localparam int unsigned COL_W     = $clog2(ARRAY_DIM);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic             last;
    logic [BUS_W-1:0] data;
  } result_t;

  function automatic logic [ARRAY_DIM-1:0] col_onehot(input logic [COL_W-1:0] col);
    return ARRAY_DIM'(1) << col;
  endfunction

endpackage

// File: rtl/systolic_sequencer_result_fifo.sv
// Synchronous result FIFO; a pop frees a slot for a push in the same cycle, no bypass.
module result_fifo
  import systolic_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       push,
  input  result_t                    push_data,
  input  logic                       pop,
  output result_t                    pop_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  result_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;

  // Credit accounting upstream must make this impossible.
  assert property (@(posedge clk) disable iff (!n_rst) !(push && full && !pop))
    else $error("result_fifo: push while full");

endmodule

// File: rtl/systolic_sequencer.sv
// Job controller for the 8x8 systolic array: weight load, credit-limited streaming, result collection.
module systolic_sequencer
  import systolic_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ROWS_W     = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 float_mode,
  input  logic [ROWS_W-1:0]    num_rows,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [BUS_W-1:0]     w_data,
  input  logic                 x_valid,
  output logic                 x_ready,
  input  logic [BUS_W-1:0]     x_data,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic [BUS_W-1:0]     r_data,
  output logic                 r_last,
  output logic [ARRAY_DIM-1:0] sa_load,
  output logic [BUS_W-1:0]     sa_input_value,
  output logic                 sa_input_valid,
  output logic                 sa_float,
  input  logic                 sa_output_valid,
  input  logic [BUS_W-1:0]     sa_output_value,
  input  logic                 sa_overflow,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow_err
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH+1);

  seq_state_t           state_q, state_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [ROWS_W-1:0]    num_rows_q, num_rows_d;
  logic [ROWS_W-1:0]    issued_q, issued_d;
  logic [ROWS_W-1:0]    received_q, received_d;
  logic [CNT_W-1:0]     outstanding_q, outstanding_d;
  logic                 float_q, float_d;
  logic                 last_popped_q, last_popped_d;
  logic                 ovf_q, ovf_d;
  logic [ARRAY_DIM-1:0] sa_load_q, sa_load_d;
  logic [BUS_W-1:0]     sa_val_q, sa_val_d;
  logic                 sa_vld_q, sa_vld_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 w_hs, x_hs, pop;
  logic                 fifo_empty, fifo_full;
  logic [CNT_W-1:0]     fifo_count;
  logic [CNT_W:0]       credit_used;
  result_t              fifo_in, fifo_out;

  // Vectors in the array plus results parked in the FIFO may never exceed its depth.
  assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign w_ready     = (state_q == LOAD_W);
  assign x_ready     = (state_q == STREAM) && (issued_q < num_rows_q) &&
                       (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign w_hs        = w_valid && w_ready;
  assign x_hs        = x_valid && x_ready;
  assign r_valid     = !fifo_empty;
  assign pop         = r_valid && r_ready;

  assign fifo_in.last = (received_q == num_rows_q - ROWS_W'(1));
  assign fifo_in.data = sa_output_value;

  result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (sa_output_valid),
    .push_data (fifo_in),
    .pop       (pop),
    .pop_data  (fifo_out),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    num_rows_d    = num_rows_q;
    float_d       = float_q;
    issued_d      = issued_q;
    received_d    = received_q;
    outstanding_d = outstanding_q + CNT_W'(x_hs) - CNT_W'(sa_output_valid);
    last_popped_d = last_popped_q;
    ovf_d         = ovf_q;
    sa_load_d     = '0;
    sa_vld_d      = 1'b0;
    sa_val_d      = sa_val_q;

    if (w_hs) begin
      sa_load_d = col_onehot(col_q);
      sa_val_d  = w_data;
    end else if (x_hs) begin
      sa_vld_d  = 1'b1;
      sa_val_d  = x_data;
    end

    if (x_hs)                 issued_d      = issued_q + ROWS_W'(1);
    if (sa_output_valid)      received_d    = received_q + ROWS_W'(1);
    if (pop && fifo_out.last) last_popped_d = 1'b1;
    if (sa_overflow && busy_q) ovf_d        = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = LOAD_W;
          float_d       = float_mode;
          num_rows_d    = num_rows;
          ovf_d         = 1'b0;
          col_d         = '0;
          issued_d      = '0;
          received_d    = '0;
          outstanding_d = '0;
          last_popped_d = 1'b0;
        end
      end
      LOAD_W: begin
        if (w_hs) begin
          col_d = col_q + COL_W'(1);
          if (col_q == COL_W'(ARRAY_DIM-1))
            state_d = (num_rows_q == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        if (issued_d == num_rows_q) state_d = DRAIN;
      end
      DRAIN: begin
        if ((outstanding_q == '0) && fifo_empty && last_popped_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      col_q         <= '0;
      num_rows_q    <= '0;
      float_q       <= 1'b0;
      issued_q      <= '0;
      received_q    <= '0;
      outstanding_q <= '0;
      last_popped_q <= 1'b0;
      ovf_q         <= 1'b0;
      sa_load_q     <= '0;
      sa_val_q      <= '0;
      sa_vld_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      num_rows_q    <= num_rows_d;
      float_q       <= float_d;
      issued_q      <= issued_d;
      received_q    <= received_d;
      outstanding_q <= outstanding_d;
      last_popped_q <= last_popped_d;
      ovf_q         <= ovf_d;
      sa_load_q     <= sa_load_d;
      sa_val_q      <= sa_val_d;
      sa_vld_q      <= sa_vld_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign sa_load        = sa_load_q;
  assign sa_input_value = sa_val_q;
  assign sa_input_valid = sa_vld_q;
  assign sa_float       = float_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign overflow_err   = ovf_q;
  assign r_data         = fifo_out.data;
  assign r_last         = fifo_out.last;

  logic unused_ok;
  assign unused_ok = fifo_full;

endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer with a behavioural 8x8 array model and a result scoreboard.
module tb_systolic_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned RW    = 16;
  localparam int          LAT   = 3;

  logic        clk = 1'b0;
  logic        n_rst, start, float_mode;
  logic [RW-1:0] num_rows;
  logic        w_valid, w_ready, x_valid, x_ready;
  logic [63:0] w_data, x_data;
  logic        r_valid, r_ready, r_last;
  logic [63:0] r_data;
  logic [7:0]  sa_load;
  logic [63:0] sa_input_value, sa_output_value;
  logic        sa_input_valid, sa_float, sa_output_valid, sa_overflow;
  logic        busy, done, overflow_err;

  systolic_sequencer #(.FIFO_DEPTH(DEPTH), .ROWS_W(RW)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .float_mode(float_mode), .num_rows(num_rows),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last),
    .sa_load(sa_load), .sa_input_value(sa_input_value), .sa_input_valid(sa_input_valid),
    .sa_float(sa_float), .sa_output_valid(sa_output_valid), .sa_output_value(sa_output_value),
    .sa_overflow(sa_overflow), .busy(busy), .done(done), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int recv_cnt = 0;
  int issued_tb = 0;
  int r_mode = 0;
  logic ovf_force = 1'b0;
  logic [7:0][63:0] cur_w;

  typedef struct {
    logic [63:0] d;
    logic        last;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int rows;
    int wsel;
    int xmode;
    int rmode;
    bit fl;
    int exp_res;
    bit exp_float;
  } job_t;
  job_t jobs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [63:0] wgt(input int wsel, input int c);
    logic [63:0] v;
    v = '0;
    for (int r = 0; r < 8; r++) begin
      case (wsel)
        0:       v[8*r +: 8] = (r == c) ? 8'h01 : 8'h00;
        1:       v[8*r +: 8] = 8'(c + 1);
        default: v[8*r +: 8] = 8'(r + c + 1);
      endcase
    end
    return v;
  endfunction

  function automatic logic [63:0] xd(input int i);
    return 64'h0807060504030201 + 64'(i);
  endfunction

  // Output byte c = sum over rows r of x[r] * W[r][c], truncated to 8 bits.
  function automatic logic [63:0] mac(input logic [63:0] x, input logic [7:0][63:0] w);
    logic [63:0] y;
    logic [7:0]  acc;
    y = '0;
    for (int c = 0; c < 8; c++) begin
      acc = '0;
      for (int r = 0; r < 8; r++) acc = acc + x[8*r +: 8] * w[c][8*r +: 8];
      y[8*c +: 8] = acc;
    end
    return y;
  endfunction

  // Behavioural array: captures columns on sa_load, fixed pipeline latency, no backpressure.
  logic [7:0][63:0] wm;
  logic [LAT-1:0]   pv;
  logic [63:0]      pd [LAT];
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pv <= '0;
      wm <= '0;
    end else begin
      for (int c = 0; c < 8; c++) if (sa_load[c]) wm[c] <= sa_input_value;
      pv    <= {pv[LAT-2:0], sa_input_valid};
      pd[0] <= mac(sa_input_value, wm);
      for (int k = 1; k < LAT; k++) pd[k] <= pd[k-1];
    end
  end
  assign sa_output_valid = pv[LAT-1];
  assign sa_output_value = pd[LAT-1];
  assign sa_overflow     = ovf_force;

  initial begin
    r_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (r_mode)
        0:       r_ready = 1'b1;
        1:       r_ready = 1'($urandom_range(0, 1));
        default: r_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (n_rst && r_valid && r_ready) begin
      recv_cnt++;
      if (sb.size() == 0) fail_now("result with empty scoreboard");
      else begin
        e = sb.pop_front();
        chk("r_data", r_data, e.d);
        chk("r_last", 64'(r_last), 64'(e.last));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int rows, input bit fl);
    start = 1'b1;
    float_mode = fl;
    num_rows = RW'(rows);
    step();
    start = 1'b0;
    chk("busy after start", 64'(busy), 64'(1));
    chk("overflow_err cleared on start", 64'(overflow_err), 64'(0));
    chk("sa_float latched", 64'(sa_float), 64'(fl));
  endtask

  task automatic send_weights(input int wsel);
    bit ok;
    int guard;
    for (int c = 0; c < 8; c++) begin
      cur_w[c] = wgt(wsel, c);
      w_valid = 1'b1;
      w_data = cur_w[c];
      ok = 1'b0;
      guard = 0;
      while (!ok && guard < 50) begin
        @(negedge clk);
        ok = w_ready;
        step();
        guard++;
      end
      if (!ok) fail_now("w handshake timeout");
      else begin
        chk("sa_load onehot", 64'(sa_load), 64'(8'(1) << c));
        chk("sa_input_value weight", sa_input_value, cur_w[c]);
      end
    end
    w_valid = 1'b0;
    w_data = '0;
  endtask

  task automatic send_x(input int n, input int rows, input int xmode);
    bit ok;
    int guard;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (xmode == 1 && (i % 2) == 1) begin
        x_valid = 1'b0;
        repeat (2) begin
          step();
          chk("sa_input_valid bubble", 64'(sa_input_valid), 64'(0));
        end
      end
      x_valid = 1'b1;
      x_data = xd(i);
      ok = 1'b0;
      guard = 0;
      while (!ok && guard < 500) begin
        @(negedge clk);
        ok = x_ready;
        if (ok) begin
          e.d = mac(x_data, cur_w);
          e.last = (i == rows - 1);
          sb.push_back(e);
          issued_tb++;
        end
        step();
        guard++;
      end
      if (!ok) begin
        fail_now("x handshake timeout");
        break;
      end
      chk("sa_input_valid beat", 64'(sa_input_valid), 64'(1));
      chk("sa_input_value act", sa_input_value, xd(i));
      chk("sa_load idle in stream", 64'(sa_load), 64'(0));
    end
    x_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done seen", 64'(seen), 64'(1));
    if (seen) begin
      chk("busy during done", 64'(busy), 64'(1));
      chk("scoreboard drained at done", 64'(sb.size()), 64'(0));
      @(negedge clk);
      chk("busy after done", 64'(busy), 64'(0));
      chk("done single cycle", 64'(done), 64'(0));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " sa_load"}, 64'(sa_load), 64'(0));
    chk({tag, " sa_input_value"}, sa_input_value, 64'(0));
    chk({tag, " sa_input_valid"}, 64'(sa_input_valid), 64'(0));
    chk({tag, " sa_float"}, 64'(sa_float), 64'(0));
    chk({tag, " r_valid"}, 64'(r_valid), 64'(0));
    chk({tag, " busy"}, 64'(busy), 64'(0));
    chk({tag, " done"}, 64'(done), 64'(0));
    chk({tag, " overflow_err"}, 64'(overflow_err), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    jobs[0] = '{rows: 0, wsel: 1, xmode: 0, rmode: 0, fl: 1'b0, exp_res: 0, exp_float: 1'b0};
    jobs[1] = '{rows: 4, wsel: 0, xmode: 0, rmode: 0, fl: 1'b1, exp_res: 4, exp_float: 1'b1};
    jobs[2] = '{rows: 6, wsel: 2, xmode: 1, rmode: 1, fl: 1'b0, exp_res: 6, exp_float: 1'b0};
    jobs[3] = '{rows: 9, wsel: 1, xmode: 1, rmode: 1, fl: 1'b1, exp_res: 9, exp_float: 1'b1};

    n_rst = 1'b0; start = 1'b0; float_mode = 1'b0; num_rows = '0;
    w_valid = 1'b0; w_data = '0; x_valid = 1'b0; x_data = '0;
    repeat (3) step();
    chk_all_zero("reset");
    @(negedge clk);
    n_rst = 1'b1;
    step();

    for (int j = 0; j < 4; j++) begin
      r_mode = jobs[j].rmode;
      recv_cnt = 0;
      start_job(jobs[j].rows, jobs[j].fl);
      send_weights(jobs[j].wsel);
      send_x(jobs[j].rows, jobs[j].rows, jobs[j].xmode);
      wait_done(2000);
      chk("job result count", 64'(recv_cnt), 64'(jobs[j].exp_res));
      chk("sa_float held after job", 64'(sa_float), 64'(jobs[j].exp_float));
      chk("no overflow_err", 64'(overflow_err), 64'(0));
      step();
    end

    // Backpressure: with r_ready low, credits stop issue once DEPTH vectors are in flight.
    r_mode = 2;
    recv_cnt = 0;
    issued_tb = 0;
    start_job(20, 1'b0);
    send_weights(1);
    fork
      send_x(20, 20, 0);
      begin
        repeat (40) step();
        chk("issued under backpressure", 64'(issued_tb), 64'(DEPTH));
        chk("x_ready held low", 64'(x_ready), 64'(0));
        chk("r_valid while full", 64'(r_valid), 64'(1));
        r_mode = 0;
      end
    join
    wait_done(3000);
    chk("backpressure result count", 64'(recv_cnt), 64'(20));
    step();

    // Overflow pulse mid-stream and an ignored start while busy.
    r_mode = 0;
    recv_cnt = 0;
    start_job(6, 1'b1);
    send_weights(0);
    fork
      send_x(6, 6, 1);
      begin
        repeat (3) step();
        ovf_force = 1'b1;
        step();
        ovf_force = 1'b0;
        step();
        chk("overflow_err set", 64'(overflow_err), 64'(1));
        start = 1'b1;
        float_mode = 1'b0;
        num_rows = RW'(2);
        step();
        start = 1'b0;
        chk("busy ignores start", 64'(busy), 64'(1));
        chk("sa_float ignores start", 64'(sa_float), 64'(1));
      end
    join
    wait_done(2000);
    chk("overflow job result count", 64'(recv_cnt), 64'(6));
    chk("overflow_err sticky in idle", 64'(overflow_err), 64'(1));
    recv_cnt = 0;
    start_job(3, 1'b0);
    send_weights(0);
    send_x(3, 3, 0);
    wait_done(2000);
    chk("restart result count", 64'(recv_cnt), 64'(3));
    step();

    // Reset with three vectors in flight, then a clean job.
    r_mode = 2;
    start_job(8, 1'b1);
    send_weights(2);
    send_x(3, 8, 0);
    n_rst = 1'b0;
    #1;
    chk_all_zero("mid-job reset");
    chk("x_ready in reset", 64'(x_ready), 64'(0));
    sb.delete();
    step();
    @(negedge clk);
    n_rst = 1'b1;
    step();
    r_mode = 1;
    recv_cnt = 0;
    start_job(5, 1'b1);
    send_weights(1);
    send_x(5, 5, 0);
    wait_done(2000);
    chk("post-reset result count", 64'(recv_cnt), 64'(5));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
